// File: rtl/alu_seq.sv
// Clocked ALU: operands captured on start, registered result/flag/zero,
// iterative shifts of up to SHIFT_STEP bit positions per cycle.
module alu_seq #(
  parameter int W          = 8,
  parameter int SHIFT_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic         flag,
  output logic         zero
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] W_C    = CW'(W);
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  // Handshake: start is sampled only while busy=0; done is a one-cycle pulse
  // after the edge that updated rslt/flag/zero, and the block is idle then.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  rslt_q, rslt_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          flag_q, flag_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;
  logic          res_wr;
  logic [CW-1:0] amt, step_k;
  logic [W:0]    sum, ext_l, ext_r;
  logic [W-1:0]  step_res;
  logic          step_out;

  assign amt    = (inB >= W'(W)) ? W_C : inB[CW-1:0];
  assign step_k = (rem_q > STEP_C) ? STEP_C : rem_q;
  assign sum    = {1'b0, inA} + {1'b0, inB};

  // The extra bit on each side catches the last bit shifted out.
  assign ext_l    = {1'b0, work_q} << step_k;
  assign ext_r    = {work_q, 1'b0} >> step_k;
  assign step_res = dir_q ? ext_r[W:1] : ext_l[W-1:0];
  assign step_out = dir_q ? ext_r[0]   : ext_l[W];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    rslt_d  = rslt_q;
    flag_d  = flag_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    res_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b1;
          res_wr = 1'b1;
          case (alu_cmd)
            3'b000: {flag_d, rslt_d} = sum;
            3'b011: rslt_d = inA ^ inB;
            3'b100: rslt_d = inB;
            3'b010: rslt_d = inA;
            3'b110: begin
              rslt_d = inA - inB;
              flag_d = (inB > inA);
            end
            3'b111: begin
              flag_d = (inA == inB);
              res_wr = 1'b0;
            end
            3'b001, 3'b101: begin
              if (amt == '0) begin
                rslt_d = inA;
                flag_d = 1'b0;
              end else begin
                done_d  = 1'b0;
                res_wr  = 1'b0;
                work_d  = inA;
                rem_d   = amt;
                dir_d   = alu_cmd[2];
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        work_d = step_res;
        rem_d  = rem_q - step_k;
        if (rem_d == '0) begin
          rslt_d  = step_res;
          flag_d  = step_out;
          res_wr  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (res_wr) zero_d = (rslt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      rslt_q  <= '0;
      flag_q  <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      rslt_q  <= rslt_d;
      flag_q  <= flag_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign rslt = rslt_q;
  assign flag = flag_q;
  assign zero = zero_q;

endmodule
